// File: rtl/traffic_config_loader.sv
// Front-panel configuration stage: debounces four push-buttons and runs the
// red/yellow/green edit FSM. Live durations change only at the commit edge.
module traffic_config_loader #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter logic [7:0]  DEFAULT_RED     = 8'd30,
  parameter logic [7:0]  DEFAULT_YELLOW  = 8'd5,
  parameter logic [7:0]  DEFAULT_GREEN   = 8'd25,
  parameter logic [7:0]  MIN_TIME        = 8'd1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_maint,
  output logic       config_mode,
  output logic       maint_mode,
  output logic [7:0] red_time,
  output logic [7:0] yellow_time,
  output logic [7:0] green_time,
  output logic [1:0] edit_field,
  output logic [7:0] edit_value
);

  localparam int unsigned    CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    RUN         = 2'd0,
    EDIT_RED    = 2'd1,
    EDIT_YELLOW = 2'd2,
    EDIT_GREEN  = 2'd3
  } state_t;

  logic [3:0]    raw;
  logic [3:0]    sync1, sync2, level, press;
  logic [CW-1:0] cnt [4];

  assign raw = {btn_maint, btn_down, btn_up, btn_mode};

  // The press pulse is registered on the flip edge, so the FSM reacts one edge later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      level <= '0;
      press <= '0;
      for (int unsigned i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int unsigned i = 0; i < 4; i++) begin
        if (sync2[i] != level[i]) begin
          if (cnt[i] == CNT_LAST) begin
            level[i] <= ~level[i];
            cnt[i]   <= '0;
            press[i] <= ~level[i];
          end else begin
            cnt[i]   <= cnt[i] + 1'b1;
            press[i] <= 1'b0;
          end
        end else begin
          cnt[i]   <= '0;
          press[i] <= 1'b0;
        end
      end
    end
  end

  logic mode_p, up_p, down_p, maint_p;
  assign mode_p  = press[0];
  assign up_p    = press[1] & ~press[2];
  assign down_p  = press[2] & ~press[1];
  assign maint_p = press[3];

  state_t     state;
  logic [7:0] sh_red, sh_yellow, sh_green;
  logic [7:0] cur, adj;

  always_comb begin
    case (state)
      EDIT_RED:    cur = sh_red;
      EDIT_YELLOW: cur = sh_yellow;
      default:     cur = sh_green;
    endcase
    if (up_p) adj = (cur == 8'hFF) ? cur : cur + 8'd1;
    else      adj = (cur <= MIN_TIME) ? MIN_TIME : cur - 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      config_mode <= 1'b0;
      maint_mode  <= 1'b0;
      red_time    <= DEFAULT_RED;
      yellow_time <= DEFAULT_YELLOW;
      green_time  <= DEFAULT_GREEN;
      sh_red      <= DEFAULT_RED;
      sh_yellow   <= DEFAULT_YELLOW;
      sh_green    <= DEFAULT_GREEN;
      edit_field  <= 2'd0;
      edit_value  <= '0;
    end else begin
      case (state)
        RUN: begin
          if (maint_p) begin
            maint_mode <= ~maint_mode;
          end else if (mode_p && !maint_mode) begin
            state       <= EDIT_RED;
            config_mode <= 1'b1;
            sh_red      <= red_time;
            sh_yellow   <= yellow_time;
            sh_green    <= green_time;
            edit_field  <= 2'd1;
            edit_value  <= red_time;
          end
        end
        EDIT_RED: begin
          if (mode_p) begin
            state      <= EDIT_YELLOW;
            edit_field <= 2'd2;
            edit_value <= sh_yellow;
          end else if (up_p || down_p) begin
            sh_red     <= adj;
            edit_value <= adj;
          end
        end
        EDIT_YELLOW: begin
          if (mode_p) begin
            state      <= EDIT_GREEN;
            edit_field <= 2'd3;
            edit_value <= sh_green;
          end else if (up_p || down_p) begin
            sh_yellow  <= adj;
            edit_value <= adj;
          end
        end
        EDIT_GREEN: begin
          if (mode_p) begin
            state       <= RUN;
            config_mode <= 1'b0;
            red_time    <= sh_red;
            yellow_time <= sh_yellow;
            green_time  <= sh_green;
            edit_field  <= 2'd0;
            edit_value  <= '0;
          end else if (up_p || down_p) begin
            sh_green   <= adj;
            edit_value <= adj;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_traffic_config_loader.sv
// Scoreboard bench for traffic_config_loader: a behavioural model queues the
// expected output snapshot per accepted press; a monitor pops on every change.
module tb_traffic_config_loader;

  localparam int DEB = 4;
  localparam logic [3:0] MODE = 4'b0001, UP = 4'b0010, DOWN = 4'b0100, MAINT = 4'b1000;

  typedef logic [35:0] snap_t;
  localparam snap_t RST_SNAP = {1'b0, 1'b0, 8'd30, 8'd5, 8'd25, 2'd0, 8'd0};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] raw = '0;
  logic       config_mode, maint_mode;
  logic [7:0] red_time, yellow_time, green_time, edit_value;
  logic [1:0] edit_field;

  traffic_config_loader #(.DEBOUNCE_CYCLES(DEB)) u_dut (
    .clk(clk), .rst(rst),
    .btn_mode(raw[0]), .btn_up(raw[1]), .btn_down(raw[2]), .btn_maint(raw[3]),
    .config_mode(config_mode), .maint_mode(maint_mode),
    .red_time(red_time), .yellow_time(yellow_time), .green_time(green_time),
    .edit_field(edit_field), .edit_value(edit_value)
  );

  always #5 clk = ~clk;

  int    n_checks = 0, n_errors = 0;
  snap_t q[$];
  int    m_state;
  bit    m_maint;
  int    m_live[3], m_sh[3];
  snap_t m_prev, prev_obs;
  bit    mon_en = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic snap_t dut_snap();
    return {config_mode, maint_mode, red_time, yellow_time, green_time, edit_field, edit_value};
  endfunction

  function automatic snap_t model_snap();
    logic [7:0] v;
    v = (m_state == 0) ? 8'd0 : 8'(m_sh[m_state-1]);
    return {m_state != 0, m_maint, 8'(m_live[0]), 8'(m_live[1]), 8'(m_live[2]), 2'(m_state), v};
  endfunction

  function automatic void model_reset();
    m_state = 0;
    m_maint = 1'b0;
    m_live  = '{30, 5, 25};
    m_sh    = '{30, 5, 25};
    m_prev  = model_snap();
  endfunction

  function automatic void model_apply(input logic [3:0] m);
    snap_t s;
    if (m_state == 0) begin
      if (m[3]) m_maint = ~m_maint;
      else if (m[0] && !m_maint) begin
        m_sh    = m_live;
        m_state = 1;
      end
    end else if (m[0]) begin
      if (m_state == 3) begin
        m_live  = m_sh;
        m_state = 0;
      end else m_state++;
    end else if (m[1] && !m[2]) begin
      if (m_sh[m_state-1] < 255) m_sh[m_state-1]++;
    end else if (m[2] && !m[1]) begin
      if (m_sh[m_state-1] > 1) m_sh[m_state-1]--;
    end
    s = model_snap();
    if (s != m_prev) begin
      q.push_back(s);
      m_prev = s;
    end
  endfunction

  // Every observed output change must match the next queued expectation.
  always @(negedge clk) begin
    snap_t s;
    s = dut_snap();
    if (mon_en && !rst && s !== prev_obs) begin
      if (q.size() == 0) check("unexpected_change", s, prev_obs);
      else               check("sb_event", s, q.pop_front());
    end
    prev_obs = s;
  end

  task automatic press(input logic [3:0] m, input int hold);
    @(posedge clk); #2;
    raw = m;
    if (hold >= DEB) model_apply(m);
    repeat (hold) @(posedge clk);
    #2 raw = '0;
    repeat (DEB + 8) @(posedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #2 rst = 1'b1;
    #1 check("rst_async", dut_snap(), RST_SNAP);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    model_reset();
    @(negedge clk);
    check("rst_state", dut_snap(), RST_SNAP);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("reset_state", dut_snap(), RST_SNAP);
    mon_en = 1'b1;

    // First mode press: config_mode must rise exactly DEB+3 edges after raw goes high.
    @(posedge clk); #2 raw = MODE;
    model_apply(MODE);
    repeat (DEB + 2) @(posedge clk);
    @(negedge clk) check("latency_before", config_mode, 1'b0);
    @(posedge clk);
    @(negedge clk) check("latency_at", config_mode, 1'b1);
    raw = '0;
    repeat (DEB + 8) @(posedge clk);

    repeat (3) press(UP, 10);
    press(MODE, 10);
    repeat (2) press(DOWN, 10);
    press(MODE, 10);
    press(UP, 10);
    press(MODE, 10);
    check("commit_live", {red_time, yellow_time, green_time, config_mode}, {8'd33, 8'd3, 8'd26, 1'b0});

    // Bounce rejection: short glitch ignored, real press counted once.
    press(MODE, 10);
    press(UP, DEB - 1);
    check("glitch_ignored", edit_value, 8'd33);
    press(UP, 10);
    check("long_press_once", edit_value, 8'd34);
    repeat (3) press(MODE, 10);

    // Saturation at both ends.
    press(MODE, 10);
    repeat (220) press(UP, 10);
    check("red_254", edit_value, 8'd254);
    repeat (3) press(UP, 10);
    check("red_sat_255", edit_value, 8'd255);
    press(MODE, 10);
    press(DOWN, 10);
    check("yellow_2", edit_value, 8'd2);
    repeat (5) press(DOWN, 10);
    check("yellow_sat_min", edit_value, 8'd1);
    repeat (2) press(MODE, 10);
    check("sat_commit", {red_time, yellow_time, green_time}, {8'd255, 8'd1, 8'd26});

    // Maintenance mode interactions.
    press(MAINT, 10);
    check("maint_on", maint_mode, 1'b1);
    press(MODE, 10);
    check("mode_blocked", config_mode, 1'b0);
    press(MAINT, 10);
    check("maint_off", maint_mode, 1'b0);
    repeat (2) press(MODE, 10);
    press(MAINT, 10);
    check("maint_in_edit", {maint_mode, edit_field}, {1'b0, 2'd2});
    press(UP | DOWN, 10);
    check("up_down_same", edit_value, 8'd1);
    press(MODE | UP, 10);
    check("mode_wins", {edit_field, edit_value}, {2'd3, 8'd26});
    press(MODE, 10);
    press(MODE | MAINT, 10);
    check("maint_wins", {maint_mode, config_mode}, {1'b1, 1'b0});
    press(MAINT, 10);

    // Reset in the middle of an edit session discards the shadow values.
    do_reset();
    press(MODE, 10);
    repeat (10) press(UP, 10);
    press(MODE, 10);
    repeat (4) press(UP, 10);
    press(MODE, 10);
    repeat (13) press(DOWN, 10);
    check("pre_rst_green", {edit_field, edit_value, red_time}, {2'd3, 8'd12, 8'd30});
    check("sb_drained", q.size(), 0);
    do_reset();
    press(MODE, 10);
    check("shadow_from_defaults", edit_value, 8'd30);

    for (int i = 0; i < 50 && q.size() != 0; i++) @(posedge clk);
    check("sb_empty", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/traffic_config_loader.md
# traffic_config_loader

Front-panel configuration stage that sits directly upstream of the traffic light controller. It debounces four raw push-buttons and runs a small edit state machine so an operator can step through the red, yellow and green durations and raise or lower each one. It drives the controller's `config_mode`, `maint_mode`, `red_time`, `yellow_time` and `green_time` inputs. The live duration outputs change only at a single commit instant, so the controller never sees a half-edited configuration.

## Interface
- `DEBOUNCE_CYCLES`, 16: consecutive stable cycles needed to accept a button level change. Must be ≥1.
- `DEFAULT_RED`, 8'd30: reset value of the red duration.
- `DEFAULT_YELLOW`, 8'd5: reset value of the yellow duration.
- `DEFAULT_GREEN`, 8'd25: reset value of the green duration.
- `MIN_TIME`, 8'd1: lower saturation bound for any duration. Every default must satisfy `MIN_TIME` ≤ default ≤ 255.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, asynchronous, active-high.
- `btn_mode`, in, 1: raw, asynchronous. Advances the edit field.
- `btn_up`, in, 1: raw, asynchronous. Increments the field being edited.
- `btn_down`, in, 1: raw, asynchronous. Decrements the field being edited.
- `btn_maint`, in, 1: raw, asynchronous. Toggles maintenance mode.
- `config_mode`, out, 1: high in every edit state.
- `maint_mode`, out, 1: maintenance flag.
- `red_time`, out, 8: committed red duration.
- `yellow_time`, out, 8: committed yellow duration.
- `green_time`, out, 8: committed green duration.
- `edit_field`, out, 2: 0 = RUN, 1 = red, 2 = yellow, 3 = green.
- `edit_value`, out, 8: shadow value of the field being edited; 0 in RUN.

## Operation
- **Input conditioning, per button:**
  - 2-FF synchronizer.
  - Debounce counter, width $clog2(DEBOUNCE_CYCLES+1). It counts while the synchronized input differs from the debounced level and clears whenever they are equal.
  - When the count reaches `DEBOUNCE_CYCLES`, the debounced level flips and the counter clears.
  - Press pulse = debounced rising edge, one cycle wide. Releases produce no event.
- **Storage:** live registers (red/yellow/green) and shadow registers (same three).
- **FSM states:** RUN, EDIT_RED, EDIT_YELLOW, EDIT_GREEN.
- **RUN:**
  - mode press with `maint_mode`=0 → EDIT_RED. Shadow ← live, all three fields.
  - mode press with `maint_mode`=1 → ignored.
  - maint press → toggle `maint_mode`.
- **Edit stepping:**
  - EDIT_RED --mode--> EDIT_YELLOW --mode--> EDIT_GREEN.
  - EDIT_GREEN --mode--> RUN. Live ← shadow, all three fields on the same edge (commit).
- **Edit states, up/down:**
  - up: current shadow field +1, saturating at 255.
  - down: current shadow field −1, saturating at `MIN_TIME`.
  - Arithmetic is 8-bit unsigned and never wraps.
- **Simultaneous events:**
  - up and down on the same cycle → both ignored.
  - mode together with up or down → mode acts, up/down ignored.
  - maint together with mode in RUN → maint toggles, mode ignored.
  - maint in any edit state → ignored.
- **No abort path:** an edit session always ends with a commit at EDIT_GREEN → RUN.
- **`config_mode`:** registered; equals (state ≠ RUN).
- **`edit_field` / `edit_value`:** registered. They reflect the state and shadow after each edge.

## Timing
- **Reset values, all outputs:**
  - `config_mode`=0, `maint_mode`=0.
  - `red_time`=`DEFAULT_RED`, `yellow_time`=`DEFAULT_YELLOW`, `green_time`=`DEFAULT_GREEN`.
  - `edit_field`=0, `edit_value`=0.
- **Reset, internal state:** state RUN; shadow = defaults; synchronizers, debounced levels and counters = 0.
- **Press latency:** the raw input goes high and is held. The resulting output change is visible after exactly `DEBOUNCE_CYCLES`+3 rising edges from the first edge that samples it high:
  - 2 edges for the synchronizer;
  - `DEBOUNCE_CYCLES` edges for the level flip;
  - 1 edge for the FSM/register update.
- **Glitch rejection:** pulses or bounce shorter than `DEBOUNCE_CYCLES` synchronized cycles produce no event.
- **Held button:** one event only; no auto-repeat.
- **Commit:** live outputs change on the same edge as `config_mode` 1→0. The three values are never seen mixed.
- **Reset mid-edit:** immediate return to reset values. Shadow edits are discarded and the live values revert to the defaults.

## Test plan
Bench uses `DEBOUNCE_CYCLES`=4.
- **Reset check:** assert then release `rst` → outputs 30/5/25, `config_mode`=0, `maint_mode`=0, `edit_field`=0.
- **Full edit, commit latency:**
  - Stimulus: mode, up ×3, mode, down ×2, mode, up ×1, mode.
  - Expected after the final mode: live outputs 33/3/26 on the same edge that `config_mode` falls.
  - Before that edge: live outputs stay 30/5/25 throughout.
  - First mode press: `config_mode` rises exactly 7 edges after the raw press.
- **Bounce rejection:** 3-cycle high glitch on `btn_up` while in EDIT_RED → no change. 10-cycle press → +1 only.
- **Saturation:**
  - Red at 254, up ×3 → `edit_value`=255.
  - Yellow at 2, down ×5 → `edit_value`=1.
- **Maintenance:**
  - maint press in RUN → `maint_mode`=1.
  - Then a mode press → `config_mode` stays 0.
  - maint press → `maint_mode`=0.
  - maint pressed inside EDIT_YELLOW → no toggle.
- **Simultaneous and reset mid-edit:**
  - Up and down debounced on the same cycle → value unchanged.
  - `rst` during EDIT_GREEN with shadow 40/9/12 → outputs 30/5/25, state RUN.
